crc16_chk: RTL

CRC16_CHK -- requirements
Module: crc16_chk

---
 rtl/crc16_chk_if.sv | 23 ++
 rtl/crc16_chk.sv | 95 +++++++++
 2 files changed

// File: rtl/crc16_chk_if.sv
// Request/result bundle for the CRC16 checker: payload + received CRC in,
// busy/valid/error/computed CRC out.
interface crc16_chk_if #(
  parameter int DATA_W = 64
);
  logic              data_ready;
  logic [DATA_W-1:0] rcv_data;
  logic [15:0]       rcv_crc;
  logic              busy;
  logic              crc_valid;
  logic              crc_err;
  logic [15:0]       calc_crc;

  modport master (
    output data_ready, rcv_data, rcv_crc,
    input  busy, crc_valid, crc_err, calc_crc
  );

  modport slave (
    input  data_ready, rcv_data, rcv_crc,
    output busy, crc_valid, crc_err, calc_crc
  );
endinterface

// File: rtl/crc16_chk.sv
// Bit-serial CRC16 checker: captures a payload and its CRC, shifts the payload
// MSB first through an LFSR (no reflection/inversion), and flags a mismatch.
module crc16_chk #(
  parameter int          DATA_W = 64,
  parameter logic [15:0] POLY   = 16'h8005
) (
  input  logic       clk,
  input  logic       rst,
  crc16_chk_if.slave bus
);
  localparam int               CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sreg;
  logic [15:0]       rcv_crc_q;
  logic [15:0]       lfsr, lfsr_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              busy_q, valid_q, err_q;
  logic [15:0]       calc_q;
  logic              load, shift, done, fb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // data_ready is only looked at in IDLE, so it cannot disturb a check in flight
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.data_ready) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (cnt == LAST) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fb       = sreg[DATA_W-1] ^ lfsr[15];
    lfsr_nxt = {lfsr[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg      <= '0;
      rcv_crc_q <= '0;
      lfsr      <= '0;
      cnt       <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      calc_q    <= '0;
    end else begin
      valid_q <= done;
      if (load) begin
        sreg      <= bus.rcv_data;
        rcv_crc_q <= bus.rcv_crc;
        lfsr      <= '0;
        cnt       <= '0;
        busy_q    <= 1'b1;
      end else if (shift) begin
        sreg <= {sreg[DATA_W-2:0], 1'b0};
        lfsr <= lfsr_nxt;
        cnt  <= cnt + 1'b1;
        // result registers only move on the final shift, so they hold between checks
        if (done) begin
          calc_q <= lfsr_nxt;
          err_q  <= (lfsr_nxt != rcv_crc_q);
          busy_q <= 1'b0;
        end
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.crc_valid = valid_q;
  assign bus.crc_err   = err_q;
  assign bus.calc_crc  = calc_q;
endmodule
